// File: rtl/vx_muldiv_issue.sv
// Issue buffer between dispatch and the muldiv unit: FIFO, request handshake, in-flight credit.
// Optional MULDIV_ISSUE_INORDER_EN holds MULs behind an outstanding DIV so responses stay ordered.

`ifndef INST_MUL_BITS
`define INST_MUL_BITS 3
`endif
`ifndef INST_MUL_IS_DIV
`define INST_MUL_IS_DIV(op) (op[2])
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

module vx_muldiv_issue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MAX_PENDING = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [`INST_MUL_BITS-1:0]     req_op,
    input  logic [`UUID_BITS-1:0]         req_uuid,
    input  logic [`NW_BITS-1:0]           req_wid,
    input  logic [`NUM_THREADS-1:0]       req_tmask,
    input  logic [31:0]                   req_PC,
    input  logic [`NR_BITS-1:0]           req_rd,
    input  logic                          req_wb,
    input  logic [`NUM_THREADS*32-1:0]    req_rs1_data,
    input  logic [`NUM_THREADS*32-1:0]    req_rs2_data,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [`INST_MUL_BITS-1:0]     iss_op,
    output logic [`UUID_BITS-1:0]         iss_uuid,
    output logic [`NW_BITS-1:0]           iss_wid,
    output logic [`NUM_THREADS-1:0]       iss_tmask,
    output logic [31:0]                   iss_PC,
    output logic [`NR_BITS-1:0]           iss_rd,
    output logic                          iss_wb,
    output logic [`NUM_THREADS*32-1:0]    iss_rs1_data,
    output logic [`NUM_THREADS*32-1:0]    iss_rs2_data,
    input  logic                          rsp_fire,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending,
    output logic                          empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    logic [`INST_MUL_BITS-1:0]  op_mem    [DEPTH];
    logic [`UUID_BITS-1:0]      uuid_mem  [DEPTH];
    logic [`NW_BITS-1:0]        wid_mem   [DEPTH];
    logic [`NUM_THREADS-1:0]    tmask_mem [DEPTH];
    logic [31:0]                pc_mem    [DEPTH];
    logic [`NR_BITS-1:0]        rd_mem    [DEPTH];
    logic                       wb_mem    [DEPTH];
    logic [`NUM_THREADS*32-1:0] rs1_mem   [DEPTH];
    logic [`NUM_THREADS*32-1:0] rs2_mem   [DEPTH];

    logic [AW:0]    wr_ptr_q, rd_ptr_q;
    logic [AW-1:0]  wr_idx, rd_idx;
    logic [PW-1:0]  pending_q, pending_d;
    logic           fifo_full, fifo_empty, issue_ok, enq, fire;

    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

`ifdef MULDIV_ISSUE_INORDER_EN
    logic div_busy_q;
    logic head_is_div;

    assign head_is_div = `INST_MUL_IS_DIV(iss_op);
    // A DIV waits for the unit to drain; a MUL waits until any issued DIV has returned.
    assign issue_ok = (pending_q < PEND_MAX) && (head_is_div ? (pending_q == '0) : !div_busy_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_busy_q <= 1'b0;
        end else if (fire && head_is_div) begin
            div_busy_q <= 1'b1;
        end else if (rsp_fire && !fire && (pending_q == PW'(1))) begin
            div_busy_q <= 1'b0;
        end
    end
`else
    assign issue_ok = (pending_q < PEND_MAX);
`endif

    assign req_ready = !fifo_full;
    assign iss_valid = !fifo_empty && issue_ok;
    assign enq       = req_valid && req_ready;
    assign fire      = iss_valid && iss_ready;
    assign pending   = pending_q;
    assign empty     = fifo_empty && (pending_q == '0);

    assign iss_op       = op_mem[rd_idx];
    assign iss_uuid     = uuid_mem[rd_idx];
    assign iss_wid      = wid_mem[rd_idx];
    assign iss_tmask    = tmask_mem[rd_idx];
    assign iss_PC       = pc_mem[rd_idx];
    assign iss_rd       = rd_mem[rd_idx];
    assign iss_wb       = wb_mem[rd_idx];
    assign iss_rs1_data = rs1_mem[rd_idx];
    assign iss_rs2_data = rs2_mem[rd_idx];

    always_comb begin
        pending_d = pending_q;
        if (fire && !rsp_fire) begin
            pending_d = pending_q + PW'(1);
        end else if (!fire && rsp_fire && (pending_q != '0)) begin
            pending_d = pending_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fire) rd_ptr_q <= rd_ptr_q + 1'b1;
            pending_q <= pending_d;
        end
    end

    // Payload storage needs no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (enq) begin
            op_mem[wr_idx]    <= req_op;
            uuid_mem[wr_idx]  <= req_uuid;
            wid_mem[wr_idx]   <= req_wid;
            tmask_mem[wr_idx] <= req_tmask;
            pc_mem[wr_idx]    <= req_PC;
            rd_mem[wr_idx]    <= req_rd;
            wb_mem[wr_idx]    <= req_wb;
            rs1_mem[wr_idx]   <= req_rs1_data;
            rs2_mem[wr_idx]   <= req_rs2_data;
        end
    end

endmodule
